prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 21 ++
 rtl/prog_loader.sv | 128 ++++++++++++
 tb/tb_prog_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states and
// instruction-memory geometry.
package loader_pkg;

    localparam int unsigned IMEM_DEPTH = 1024;
    localparam int unsigned IW         = 9;
    localparam int unsigned AW         = 10;
    localparam int unsigned CW         = 11;
    localparam int unsigned LAST_BIT   = 7;
    localparam int unsigned HI_BIT     = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LO      = 3'd1,
        HI      = 3'd2,
        WRITE   = 3'd3,
        RELEASE = 3'd4,
        DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/prog_loader.sv
// Assembles 9-bit instruction words from byte pairs, writes them to instruction
// memory, and holds the core in init until the last word (or a full memory).
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = loader_pkg::IMEM_DEPTH
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          go,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [IW-1:0] wr_data,
    output logic          core_start,
    output logic          done,
    output logic [CW-1:0] word_count,
    output logic          overflow
);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [IW-1:0] word_q, word_d;
    logic          last_q, last_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          in_ready_q, in_ready_d;
    logic          wr_en_q, wr_en_d;
    logic          core_start_q, core_start_d;
    logic          done_q, done_d;
    logic          xfer_c;
    logic          unused_in_bits_c;

    // Middle bits of the high byte carry no information.
    assign unused_in_bits_c = ^in_data[6:1];
    assign xfer_c           = in_valid && in_ready_q;

    // Next state, datapath updates, and state-decoded outputs one cycle ahead.
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        word_d       = word_q;
        last_d       = last_q;
        count_d      = count_q;
        overflow_d   = overflow_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d    = LO;
                    wr_addr_d  = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            LO: begin
                if (xfer_c) begin
                    word_d[7:0] = in_data;
                    state_d     = HI;
                end
            end
            HI: begin
                if (xfer_c) begin
                    word_d[IW-1] = in_data[HI_BIT];
                    last_d       = in_data[LAST_BIT];
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                count_d = count_q + CW'(1);
                if (last_q) begin
                    state_d = RELEASE;
                end else if (wr_addr_q == AW'(IMEM_DEPTH - 1)) begin
                    overflow_d = 1'b1;
                    state_d    = RELEASE;
                end else begin
                    wr_addr_d = wr_addr_q + AW'(1);
                    state_d   = LO;
                end
            end
            RELEASE: state_d = DONE;
            default: state_d = IDLE;
        endcase

        in_ready_d   = (state_d == LO) || (state_d == HI);
        wr_en_d      = (state_d == WRITE);
        core_start_d = (state_d != DONE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            core_start_q <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            word_q       <= word_d;
            last_q       <= last_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            core_start_q <= core_start_d;
            done_q       <= done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = word_q;
    assign core_start = core_start_q;
    assign done       = done_q;
    assign word_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: normal loads, backpressure,
// reload, mid-load reset and memory-full overflow.
module tb_prog_loader;

    logic        CLK = 1'b0;
    logic        reset;
    logic        go;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [8:0]  wr_data;
    logic        core_start;
    logic        done;
    logic [10:0] word_count;
    logic        overflow;

    prog_loader dut (
        .CLK        (CLK),
        .reset      (reset),
        .go         (go),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_start (core_start),
        .done       (done),
        .word_count (word_count),
        .overflow   (overflow)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Write/transfer monitor sampled on the falling edge.
    logic [9:0] log_addr[$];
    logic [8:0] log_data[$];
    int         xfer_n        = 0;
    int         last_xfer_cyc = 0;
    int         last_wr_cyc   = 0;
    int         cs_fall_cyc   = 0;
    logic       prev_cs       = 1'b1;

    always @(negedge CLK) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            last_wr_cyc = cyc;
            check_eq("wr_latency", 32'(cyc - last_xfer_cyc), 32'd1);
            check_eq("ready_in_write", 32'(in_ready), 32'd0);
        end
        if (in_valid === 1'b1 && in_ready === 1'b1 && reset === 1'b0) begin
            xfer_n++;
            last_xfer_cyc = cyc;
        end
        if (prev_cs === 1'b1 && core_start === 1'b0) cs_fall_cyc = cyc;
        prev_cs = core_start;
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        xfer_n = 0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(posedge CLK); #1;
        go = 1'b0;
    endtask

    // Present a byte and keep it valid until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge CLK);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (in_ready !== 1'b1) check_eq("xfer_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge CLK);
        while (done !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (done !== 1'b1) check_eq("done_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [8:0] w;
        int         bad;

        reset    = 1'b1;
        go       = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_core_start", 32'(core_start), 32'd1);
        check_eq("rst_done",       32'(done),       32'd0);
        check_eq("rst_in_ready",   32'(in_ready),   32'd0);
        check_eq("rst_wr_en",      32'(wr_en),      32'd0);
        check_eq("rst_wr_addr",    32'(wr_addr),    32'd0);
        check_eq("rst_wr_data",    32'(wr_data),    32'd0);
        check_eq("rst_word_count", 32'(word_count), 32'd0);
        check_eq("rst_overflow",   32'(overflow),   32'd0);
        reset = 1'b0;
        @(posedge CLK); #1;

        // Three-word load with in_valid held high from before go onwards.
        clear_log();
        in_valid = 1'b1;
        in_data  = 8'h12;
        @(posedge CLK); #1;
        check_eq("idle_hold_ready", 32'(in_ready), 32'd0);
        pulse_go();
        send_byte(8'h12); send_byte(8'h01);
        send_byte(8'h34); send_byte(8'h00);
        send_byte(8'h56); send_byte(8'h80);
        in_valid = 1'b0;
        wait_done();
        check_eq("w3_nwrites", 32'(log_addr.size()), 32'd3);
        check_eq("w3_xfers",   32'(xfer_n), 32'd6);
        if (log_addr.size() == 3) begin
            check_eq("w3_a0", 32'(log_addr[0]), 32'h000);
            check_eq("w3_d0", 32'(log_data[0]), 32'h112);
            check_eq("w3_a1", 32'(log_addr[1]), 32'h001);
            check_eq("w3_d1", 32'(log_data[1]), 32'h034);
            check_eq("w3_a2", 32'(log_addr[2]), 32'h002);
            check_eq("w3_d2", 32'(log_data[2]), 32'h056);
        end
        check_eq("w3_count",      32'(word_count), 32'd3);
        check_eq("w3_overflow",   32'(overflow),   32'd0);
        check_eq("w3_core_start", 32'(core_start), 32'd0);
        check_eq("w3_done",       32'(done),       32'd1);
        check_eq("w3_cs_latency", 32'(cs_fall_cyc - last_wr_cyc), 32'd2);

        // Reload from DONE, go ignored in HI, single word flagged last.
        clear_log();
        pulse_go();
        check_eq("reload_core_start", 32'(core_start), 32'd1);
        check_eq("reload_done",       32'(done),       32'd0);
        check_eq("reload_count",      32'(word_count), 32'd0);
        send_byte(8'hFF);
        in_valid = 1'b0;
        pulse_go();
        check_eq("go_in_hi_ready", 32'(in_ready), 32'd1);
        check_eq("go_in_hi_wr_en", 32'(wr_en),    32'd0);
        send_byte(8'h81);
        in_valid = 1'b0;
        wait_done();
        check_eq("w1_nwrites", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            check_eq("w1_a0", 32'(log_addr[0]), 32'h000);
            check_eq("w1_d0", 32'(log_data[0]), 32'h1FF);
        end
        check_eq("w1_count", 32'(word_count), 32'd1);

        // Reset (with go) after the low byte of word 5.
        clear_log();
        pulse_go();
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(i + 8'h40));
            send_byte(8'h00);
        end
        send_byte(8'h77);
        in_valid = 1'b0;
        check_eq("pre_rst_count", 32'(word_count), 32'd5);
        clear_log();
        reset = 1'b1;
        go    = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        go    = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        check_eq("midrst_writes",     32'(log_addr.size()), 32'd0);
        check_eq("midrst_core_start", 32'(core_start), 32'd1);
        check_eq("midrst_count",      32'(word_count), 32'd0);
        check_eq("midrst_in_ready",   32'(in_ready),   32'd0);
        check_eq("midrst_done",       32'(done),       32'd0);

        // Fill all 1024 words with no last flag.
        clear_log();
        pulse_go();
        for (int i = 0; i < 1024; i++) begin
            w = 9'(i);
            send_byte(w[7:0]);
            send_byte(8'(w[8]));
        end
        in_valid = 1'b0;
        wait_done();
        check_eq("ovf_nwrites", 32'(log_addr.size()), 32'd1024);
        bad = 0;
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_addr[i] !== 10'(i) || log_data[i] !== 9'(i)) bad++;
        end
        check_eq("ovf_bad_entries", 32'(bad), 32'd0);
        if (log_addr.size() > 0) begin
            check_eq("ovf_last_addr", 32'(log_addr[log_addr.size() - 1]), 32'h3FF);
        end
        check_eq("ovf_count",    32'(word_count), 32'd1024);
        check_eq("ovf_overflow", 32'(overflow),   32'd1);
        check_eq("ovf_done",     32'(done),       32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
